rxframe: RTL and testbench

RXFRAME -- requirements
Module: rxframe

---
 rtl/rxframe_pkg.sv | 37 +++
 rtl/rxfifo.sv | 61 ++++++
 rtl/rxframe.sv | 98 +++++++++
 tb/tb_rxframe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rxframe_pkg.sv
// rxframe_pkg: definitions shared by the receive-frame checker and its FIFO.
//   - The 11-bit frame layout arrives LSB first on the line:
//     start bit, eight data bits, parity bit, stop bit.
//   - Parity-mode constants.
//   - The stored FIFO entry layout: the parity-error tag above the data byte.
//   - Helper functions that decode framing and parity errors.
package rxframe_pkg;

    localparam int FRAME_W      = 11;
    localparam int BIT_START    = 0;
    localparam int BIT_DATA_LSB = 1;
    localparam int BIT_DATA_MSB = 8;
    localparam int BIT_PAR      = 9;
    localparam int BIT_STOP     = 10;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic frame_err(input logic [FRAME_W-1:0] frame);
        return frame[BIT_START] | ~frame[BIT_STOP];
    endfunction

    // The reduction over the data bits and the parity bit must equal the
    // mode bit: 0 for even parity, 1 for odd parity.
    function automatic logic parity_err(input logic [FRAME_W-1:0] frame,
                                        input logic               mode);
        return (^frame[BIT_PAR:BIT_DATA_LSB]) != mode;
    endfunction

endpackage

// File: rtl/rxfifo.sv
// rxfifo: first-word-fall-through FIFO that stores the checked receive
// entries.
//   i_Pclk, i_Rst_n  clock; asynchronous active-low reset
//   push, wdata      write request and the entry to store
//   pop              read request; it is ignored while the FIFO is empty
//   rdata            head entry; meaningful only while empty=0
//   full, empty      status, derived from the pointers
//   count            number of stored entries (wptr - rptr)
// A push while full is accepted only when a pop happens on the same edge.
module rxfifo
    import rxframe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     i_Pclk,
    input  logic                     i_Rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // The pointers carry one extra bit so that full and empty can be told
    // apart. They wrap modulo 2*DEPTH.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage is not reset. Entries are only ever read between the pointers.
    always_ff @(posedge i_Pclk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;

endmodule

// File: rtl/rxframe.sv
// rxframe: checks received frames and queues the good ones.
//   i_Pclk, i_Rst_n  clock; asynchronous active-low reset
//   i_Frame, i_Done  frame from the shifter, qualified by a one-cycle strobe
//   o_Data, o_Perr   head entry: data byte and its parity-error tag
//   o_Valid, i_Ready head valid; the consumer accepts the head
//   o_Count          number of queued entries
//   o_Ferr           sticky framing error
//   o_Overrun        sticky overrun
//   i_Err_Clr        clears both sticky flags
// Frames pass through a one-deep register stage and are checked one cycle
// after the strobe. A frame with a framing error is dropped. Any other
// frame is queued, tagged with its parity result.
module rxframe
    import rxframe_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                     i_Pclk,
    input  logic                     i_Rst_n,
    input  logic [FRAME_W-1:0]       i_Frame,
    input  logic                     i_Done,
    output logic [7:0]               o_Data,
    output logic                     o_Perr,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Ferr,
    output logic                     o_Overrun,
    input  logic                     i_Err_Clr
);

    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    logic               s1_valid;
    logic [FRAME_W-1:0] s1_frame;
    logic               s1_ferr;
    logic               good_push;
    logic               ferr_evt;
    logic               ovr_evt;
    logic               fifo_full;
    logic               fifo_empty;
    rx_entry_t          wr_entry;
    rx_entry_t          rd_entry;

    // The stage advances every cycle, so back-to-back strobes flow through
    // in order without a stall.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) s1_valid <= 1'b0;
        else          s1_valid <= i_Done;
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Done) s1_frame <= i_Frame;
    end

    assign s1_ferr   = frame_err(s1_frame);
    assign ferr_evt  = s1_valid & s1_ferr;
    assign good_push = s1_valid & ~s1_ferr;

    // The FIFO can only be full when it is not empty, so i_Ready alone tells
    // whether a pop frees a slot on this edge.
    assign ovr_evt = good_push & fifo_full & ~i_Ready;

    assign wr_entry.perr = parity_err(s1_frame, PAR_MODE);
    assign wr_entry.data = s1_frame[BIT_DATA_MSB:BIT_DATA_LSB];

    // A new error event takes priority over a clear on the same edge.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Ferr    <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            o_Ferr    <= ferr_evt | (o_Ferr    & ~i_Err_Clr);
            o_Overrun <= ovr_evt  | (o_Overrun & ~i_Err_Clr);
        end
    end

    rxfifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_Pclk  (i_Pclk),
        .i_Rst_n (i_Rst_n),
        .push    (good_push),
        .wdata   (wr_entry),
        .pop     (i_Ready),
        .rdata   (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_Count)
    );

    assign o_Valid = ~fifo_empty;
    assign o_Data  = rd_entry.data;
    assign o_Perr  = rd_entry.perr;

endmodule

// File: tb/tb_rxframe.sv
module tb_rxframe;

    logic        i_Pclk = 1'b0;
    logic        i_Rst_n;
    logic [10:0] i_Frame;
    logic        i_Done;
    logic [7:0]  o_Data;
    logic        o_Perr;
    logic        o_Valid;
    logic        i_Ready;
    logic [2:0]  o_Count;
    logic        o_Ferr;
    logic        o_Overrun;
    logic        i_Err_Clr;

    int n_cmp = 0;
    int n_err = 0;

    rxframe #(.DEPTH(4), .PARITY_ODD(0)) dut (
        .i_Pclk    (i_Pclk),
        .i_Rst_n   (i_Rst_n),
        .i_Frame   (i_Frame),
        .i_Done    (i_Done),
        .o_Data    (o_Data),
        .o_Perr    (o_Perr),
        .o_Valid   (o_Valid),
        .i_Ready   (i_Ready),
        .o_Count   (o_Count),
        .o_Ferr    (o_Ferr),
        .o_Overrun (o_Overrun),
        .i_Err_Clr (i_Err_Clr)
    );

    always #5 i_Pclk = ~i_Pclk;

    typedef struct {
        logic [10:0] frame;
        logic        done;
        logic        rdy;
        logic        clr;
        logic        valid;
        logic [7:0]  data;
        logic        perr;
        logic [2:0]  count;
        logic        ferr;
        logic        ovr;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mkv(input logic [10:0] frame, input logic done,
                                 input logic rdy, input logic clr,
                                 input logic valid, input logic [7:0] data,
                                 input logic perr, input logic [2:0] count,
                                 input logic ferr, input logic ovr);
        vec_t v;
        v.frame = frame; v.done = done; v.rdy = rdy; v.clr = clr;
        v.valid = valid; v.data = data; v.perr = perr; v.count = count;
        v.ferr = ferr; v.ovr = ovr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic valid, input logic [7:0] data,
                            input logic perr, input logic [2:0] count,
                            input logic ferr, input logic ovr);
        chk({tag, ".valid"}, 32'(o_Valid), 32'(valid));
        chk({tag, ".count"}, 32'(o_Count), 32'(count));
        chk({tag, ".ferr"},  32'(o_Ferr),  32'(ferr));
        chk({tag, ".ovr"},   32'(o_Overrun), 32'(ovr));
        if (valid) begin
            chk({tag, ".data"}, 32'(o_Data), 32'(data));
            chk({tag, ".perr"}, 32'(o_Perr), 32'(perr));
        end
    endtask

    task automatic drive(input logic [10:0] frame, input logic done,
                         input logic rdy, input logic clr);
        i_Frame   = frame;
        i_Done    = done;
        i_Ready   = rdy;
        i_Err_Clr = clr;
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next
    // falling edge, after the rising edge in between has acted.
    task automatic step();
        @(negedge i_Pclk);
    endtask

    function automatic logic [7:0] sdat(input int j);
        return 8'h30 + 8'(j * 7);
    endfunction

    function automatic logic [10:0] good_frame(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    localparam logic [10:0] F_GOOD = 11'b10100011010;
    localparam logic [10:0] F_STOP = 11'b00100011010;
    localparam logic [10:0] F_PAR  = 11'b11100011010;
    localparam logic [10:0] F_STRT = 11'b10100011011;
    localparam logic [10:0] F_IDLE = 11'h000;

    initial begin
        tbl[0]  = mkv(F_GOOD, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mkv(F_IDLE, 0, 0, 0,  1, 8'h8D, 0, 1, 0, 0);
        tbl[2]  = mkv(F_IDLE, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[3]  = mkv(F_STOP, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[4]  = mkv(F_IDLE, 0, 0, 0,  0, 8'h00, 0, 0, 1, 0);
        tbl[5]  = mkv(F_IDLE, 0, 0, 0,  0, 8'h00, 0, 0, 1, 0);
        tbl[6]  = mkv(F_IDLE, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        tbl[7]  = mkv(F_PAR,  1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[8]  = mkv(F_IDLE, 0, 0, 0,  1, 8'h8D, 1, 1, 0, 0);
        tbl[9]  = mkv(F_IDLE, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[10] = mkv(F_STOP, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[11] = mkv(F_IDLE, 0, 0, 1,  0, 8'h00, 0, 0, 1, 0);
        tbl[12] = mkv(F_IDLE, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        tbl[13] = mkv({1'b1, 1'b0, 8'hA5, 1'b0}, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[14] = mkv({1'b1, 1'b0, 8'h3C, 1'b0}, 1, 0, 0,  1, 8'hA5, 0, 1, 0, 0);
        tbl[15] = mkv({1'b1, 1'b0, 8'hF0, 1'b0}, 1, 0, 0,  1, 8'hA5, 0, 2, 0, 0);
        tbl[16] = mkv(F_IDLE, 0, 0, 0,  1, 8'hA5, 0, 3, 0, 0);
        tbl[17] = mkv(F_IDLE, 0, 1, 0,  1, 8'h3C, 0, 2, 0, 0);
        tbl[18] = mkv(F_IDLE, 0, 1, 0,  1, 8'hF0, 0, 1, 0, 0);
        tbl[19] = mkv(F_IDLE, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[20] = mkv(F_STRT, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
        tbl[21] = mkv(F_IDLE, 0, 0, 0,  0, 8'h00, 0, 0, 1, 0);
        tbl[22] = mkv(F_IDLE, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);

        drive(F_IDLE, 0, 0, 0);
        i_Rst_n = 1'b0;
        repeat (3) step();
        chk_outs("reset", 0, 8'h00, 0, 0, 0, 0);
        i_Rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].frame, tbl[i].done, tbl[i].rdy, tbl[i].clr);
            step();
            chk_outs($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].perr,
                     tbl[i].count, tbl[i].ferr, tbl[i].ovr);
        end

        // Overrun: five frames into a depth-4 FIFO with no consumer
        drive({1'b1, 1'b0, 8'h11, 1'b0}, 1, 0, 0); step();
        drive({1'b1, 1'b0, 8'h22, 1'b0}, 1, 0, 0); step();
        drive({1'b1, 1'b0, 8'h44, 1'b0}, 1, 0, 0); step();
        drive({1'b1, 1'b0, 8'h88, 1'b0}, 1, 0, 0); step();
        drive({1'b1, 1'b1, 8'h07, 1'b0}, 1, 0, 0); step();
        chk_outs("ovr_fill4", 1, 8'h11, 0, 4, 0, 0);
        drive(F_IDLE, 0, 0, 0); step();
        chk_outs("ovr_5th", 1, 8'h11, 0, 4, 0, 1);
        drive(F_IDLE, 0, 1, 0); step();
        chk_outs("ovr_pop1", 1, 8'h22, 0, 3, 0, 1);
        step();
        chk_outs("ovr_pop2", 1, 8'h44, 0, 2, 0, 1);
        step();
        chk_outs("ovr_pop3", 1, 8'h88, 0, 1, 0, 1);
        step();
        chk_outs("ovr_pop4", 0, 8'h00, 0, 0, 0, 1);
        drive(F_IDLE, 0, 0, 1); step();
        chk_outs("ovr_clr", 0, 8'h00, 0, 0, 0, 0);

        // Simultaneous push and pop while full, streaming past several wraps
        for (int i = 0; i <= 16; i++) begin
            if (i <= 15) drive(good_frame(sdat(i)), 1, (i >= 5), 0);
            else         drive(F_IDLE, 0, 1, 0);
            step();
            if (i >= 4)
                chk_outs($sformatf("full_pp%0d", i), 1, sdat(i - 4), 0, 4, 0, 0);
        end
        for (int i = 17; i <= 20; i++) begin
            drive(F_IDLE, 0, 1, 0);
            step();
            if (i < 20) chk_outs($sformatf("drain%0d", i), 1, sdat(i - 4), 0, 3'(20 - i), 0, 0);
            else        chk_outs("drain_empty", 0, 8'h00, 0, 0, 0, 0);
        end

        // Asynchronous reset with two entries stored and a frame in stage 1
        drive({1'b1, 1'b0, 8'h66, 1'b0}, 1, 0, 0); step();
        drive({1'b1, 1'b0, 8'h99, 1'b0}, 1, 0, 0); step();
        drive(F_IDLE, 0, 0, 0); step();
        chk_outs("rst_pre", 1, 8'h66, 0, 2, 0, 0);
        drive({1'b1, 1'b0, 8'hC3, 1'b0}, 1, 0, 0); step();
        drive(F_IDLE, 0, 0, 0);
        #2 i_Rst_n = 1'b0;
        #1 chk_outs("rst_async", 0, 8'h00, 0, 0, 0, 0);
        step(); step();
        i_Rst_n = 1'b1;
        step();
        chk_outs("rst_release", 0, 8'h00, 0, 0, 0, 0);
        drive({1'b1, 1'b0, 8'h5A, 1'b0}, 1, 0, 0); step();
        chk_outs("rst_next0", 0, 8'h00, 0, 0, 0, 0);
        drive(F_IDLE, 0, 0, 0); step();
        chk_outs("rst_next1", 1, 8'h5A, 0, 1, 0, 0);
        drive(F_IDLE, 0, 1, 0); step();
        chk_outs("rst_next_pop", 0, 8'h00, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
